// File: rtl/axi4l_pkg.sv
// axi4l_pkg: AXI4-lite response codes, initiator FSM states and strobe helper
package axi4l_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
  function automatic logic [3:0] sel_to_strb(input logic [31:0] sel);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = |sel[8*i +: 8];
    return s;
  endfunction
  function automatic logic resp_err(input logic [1:0] r);
    return r == RESP_SLVERR || r == RESP_DECERR;
  endfunction
endpackage

// File: rtl/axi4l_initiator.sv
// axi4l_initiator: single-outstanding request bus to AXI4-lite master with response timeout
module axi4l_initiator
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  req_wr_i,
  input  logic                  req_rd_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_data_i,
  input  logic [31:0]           req_sel_i,
  output logic                  busy_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [31:0]           rd_data_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic [2:0]            awprot_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb_o,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [2:0]            arprot_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [31:0]           rdata_i,
  input  logic [1:0]            rresp_i
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0] cnt;
  logic accept_wr, accept_rd, b_done, r_done, done, tout;
  assign accept_wr = state == IDLE && req_wr_i;
  assign accept_rd = state == IDLE && req_rd_i && !req_wr_i;
  assign b_done    = state == WRESP && bvalid_i;
  assign r_done    = state == RDATA && rvalid_i;
  assign done      = b_done || r_done;
  // a response landing on the expiry cycle still completes normally
  assign tout      = TIMEOUT != 0 && state != IDLE && !done && cnt == CW'(TIMEOUT - 1);
  assign busy_o    = state != IDLE;
  assign awaddr_o  = addr;
  assign araddr_o  = addr;
  assign awprot_o  = 3'b000;
  assign arprot_o  = 3'b000;
  assign bready_o  = 1'b1;
  assign rready_o  = 1'b1;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_wr_i ? WADDR : req_rd_i ? RADDR : IDLE;
      WADDR:   state_n = (awvalid_o && !awready_i) || (wvalid_o && !wready_i) ? WADDR : WRESP;
      WRESP:   state_n = bvalid_i ? IDLE : WRESP;
      RADDR:   state_n = arready_i ? RDATA : RADDR;
      RDATA:   state_n = rvalid_i ? IDLE : RDATA;
      default: state_n = IDLE;
    endcase
    if (tout) state_n = IDLE;
  end
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      awvalid_o <= 1'b0;
      wvalid_o  <= 1'b0;
      arvalid_o <= 1'b0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      rd_data_o <= '0;
      addr      <= '0;
      wdata_o   <= '0;
      wstrb_o   <= '0;
      cnt       <= '0;
    end else begin
      awvalid_o <= accept_wr || (awvalid_o && !awready_i && !tout);
      wvalid_o  <= accept_wr || (wvalid_o && !wready_i && !tout);
      arvalid_o <= accept_rd || (arvalid_o && !arready_i && !tout);
      ack_o     <= done || tout;
      err_o     <= b_done ? resp_err(bresp_i) : r_done ? resp_err(rresp_i) : tout;
      cnt       <= state == IDLE ? '0 : cnt + 1'b1;
      if (r_done) rd_data_o <= rdata_i;
      else if (tout) rd_data_o <= '0;
      if (accept_wr || accept_rd) addr <= req_addr_i;
      if (accept_wr) begin
        wdata_o <= req_data_i;
        wstrb_o <= sel_to_strb(req_sel_i);
      end
    end
endmodule

// File: tb/tb_axi4l_initiator.sv
// tb_axi4l_initiator: randomized request traffic against a cycle-latency model of the initiator
module tb_axi4l_initiator;
  localparam int TO = 8;
  logic aclk = 1'b0, areset_n = 1'b0;
  logic req_wr_i = 0, req_rd_i = 0;
  logic [31:0] req_addr_i = 0, req_data_i = 0, req_sel_i = 0;
  logic busy_o, ack_o, err_o;
  logic [31:0] rd_data_o;
  logic awvalid_o, awready_i = 0, wvalid_o, wready_i = 0, bvalid_i = 0, bready_o;
  logic arvalid_o, arready_i = 0, rvalid_i = 0, rready_o;
  logic [31:0] awaddr_o, araddr_o, wdata_o, rdata_i = 0;
  logic [2:0] awprot_o, arprot_o;
  logic [3:0] wstrb_o;
  logic [1:0] bresp_i = 0, rresp_i = 0;
  int n_tests = 0, n_fail = 0;

  axi4l_initiator #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req_wr_i(req_wr_i), .req_rd_i(req_rd_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_sel_i(req_sel_i),
    .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o), .rd_data_o(rd_data_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awprot_o(awprot_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arprot_o(arprot_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // d0: aw/ar ready delay, d1: w ready delay, d2: response delay; hang = read never answered
  task automatic run_txn(input bit is_wr, input bit both, input bit extra, input bit hang,
                         input int d0, input int d1, input int d2,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] sel,
                         input logic [1:0] resp, input logic [31:0] rd);
    int exp_ack, got_ack, n_ack, mx;
    logic [3:0] strb;
    logic got_err, bad_pay, rd_issued, v_at_ack;
    logic [31:0] got_rd;
    mx = d0 > d1 ? d0 : d1;
    exp_ack = hang ? TO + 1 : is_wr ? 3 + mx + d2 : 3 + d0 + d2;
    for (int i = 0; i < 4; i++) strb[i] = sel[8*i +: 8] != 8'h00;
    got_ack = 0; n_ack = 0; got_err = 0; got_rd = 0; bad_pay = 0; rd_issued = 0; v_at_ack = 1;
    @(negedge aclk);
    {awready_i, wready_i, arready_i, bvalid_i, rvalid_i} = '0;
    req_wr_i = is_wr; req_rd_i = !is_wr || both;
    req_addr_i = addr; req_data_i = data; req_sel_i = sel;
    bresp_i = resp; rresp_i = resp; rdata_i = rd;
    for (int c = 1; c <= exp_ack + 3; c++) begin
      @(negedge aclk);
      if (c == 1) begin
        check("issue_busy", busy_o, 1);
        check("issue_valids", {awvalid_o, wvalid_o, arvalid_o}, is_wr ? 3'b110 : 3'b001);
        if (is_wr) check("issue_wstrb", wstrb_o, strb);
      end
      if (ack_o) begin
        n_ack++;
        if (got_ack == 0) begin got_ack = c; got_err = err_o; got_rd = rd_data_o; end
      end
      if (c == exp_ack) v_at_ack = awvalid_o | wvalid_o | arvalid_o | busy_o;
      if (awvalid_o && awaddr_o !== addr) bad_pay = 1;
      if (wvalid_o && (wdata_o !== data || wstrb_o !== strb)) bad_pay = 1;
      if (arvalid_o && araddr_o !== addr) bad_pay = 1;
      if (is_wr && arvalid_o) rd_issued = 1;
      req_wr_i = extra && c == 2; req_rd_i = 0;
      if (extra && c == 2) req_addr_i = ~addr;
      awready_i = is_wr && c == 1 + d0;
      wready_i  = is_wr && c == 1 + d1;
      arready_i = !is_wr && c == 1 + d0;
      bvalid_i  = is_wr ? !hang && c == 2 + mx + d2 : $urandom_range(0, 3) == 0;
      rvalid_i  = is_wr ? $urandom_range(0, 3) == 0 : hang ? c == exp_ack + 1 : c == 2 + d0 + d2;
    end
    check("ack_cycle", got_ack, exp_ack);
    check("ack_count", n_ack, 1);
    check("ack_err", got_err, hang ? 1'b1 : resp[1]);
    if (!is_wr) check("rd_data", got_rd, hang ? 32'h0 : rd);
    check("payload_stable", bad_pay, 0);
    check("idle_at_ack", v_at_ack, 0);
    if (both) check("read_dropped", rd_issued, 0);
  endtask

  initial begin
    int ack_seen;
    logic [31:0] sel;
    repeat (3) @(negedge aclk);
    check("rst_flags", {awvalid_o, wvalid_o, arvalid_o, busy_o, ack_o, err_o}, 6'b0);
    check("rst_regs", {rd_data_o, awaddr_o}, 64'h0);
    check("rst_wregs", {wdata_o, wstrb_o}, 36'h0);
    check("const_outs", {bready_o, rready_o, awprot_o, arprot_o}, 8'b1100_0000);
    areset_n = 1'b1;
    run_txn(1, 0, 0, 0, 0, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0000FFFF, 2'b00, 0);
    run_txn(0, 0, 0, 0, 3, 0, 0, 32'h20, 0, 0, 2'b00, 32'h12345678);
    run_txn(1, 0, 0, 0, 2, 0, 0, 32'h44, 32'hCAFE0001, 32'hFF00FF00, 2'b10, 0);
    run_txn(0, 0, 0, 1, 0, 0, 0, 32'h30, 0, 0, 2'b00, 32'hAAAA5555);
    run_txn(0, 0, 0, 1, 99, 0, 0, 32'h34, 0, 0, 2'b00, 32'h5555AAAA);
    run_txn(1, 1, 1, 0, 1, 1, 1, 32'h50, 32'h0BADF00D, 32'hFFFFFFFF, 2'b11, 0);
    @(negedge aclk);
    {awready_i, wready_i, arready_i, bvalid_i, rvalid_i} = '0;
    req_wr_i = 1; req_addr_i = 32'h60; req_data_i = 32'h1; req_sel_i = 32'hFF;
    @(negedge aclk);
    req_wr_i = 0;
    @(negedge aclk);
    #2 areset_n = 1'b0;
    #1 check("async_rst", {awvalid_o, wvalid_o, arvalid_o, busy_o, ack_o}, 5'b0);
    @(negedge aclk);
    areset_n = 1'b1;
    ack_seen = 0;
    repeat (4) @(negedge aclk) if (ack_o || busy_o) ack_seen++;
    check("no_ack_after_rst", ack_seen, 0);
    run_txn(1, 0, 0, 0, 0, 0, 0, 32'h64, 32'h87654321, 32'hFF000000, 2'b00, 0);
    for (int n = 0; n < 40; n++) begin
      bit is_wr;
      is_wr = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 4; i++) sel[8*i +: 8] = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
      run_txn(is_wr, is_wr && $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              !is_wr && $urandom_range(0, 7) == 0,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom & 32'hFFFC, $urandom, sel, 2'($urandom_range(0, 3)), $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
